// File: rtl/hsclk_sel_ctrl_pkg.sv
// Shared definitions for the fast-clock select controller.
//  state_e         : controller states (LS_RUN, HS_REQ, HS_RUN, LS_REQ)
//  CFG_*           : bit positions inside the 8-bit speed config register
//  pack_rdata()    : assembles the config read-back word
package hsclk_sel_ctrl_pkg;

  typedef enum logic [1:0] {
    LS_RUN = 2'd0,
    HS_REQ = 2'd1,
    HS_RUN = 2'd2,
    LS_REQ = 2'd3
  } state_e;

  // Write-side and read-side bit positions of the config register
  localparam int unsigned CFG_TURBO_BIT = 0;
  localparam int unsigned CFG_DIV_LSB   = 1;
  localparam int unsigned CFG_DIV_MSB   = 2;
  localparam int unsigned CFG_HSACT_BIT = 4;
  localparam int unsigned CFG_ERR_BIT   = 7;

  // Read-back layout: {err, 2'b0, hs_active, 1'b0, div_pend[1:0], turbo_en}
  function automatic logic [7:0] pack_rdata(input logic       err,
                                            input logic       hs_act,
                                            input logic [1:0] div,
                                            input logic       turbo);
    logic [7:0] w;
    w                = 8'h00;
    w[CFG_ERR_BIT]   = err;
    w[CFG_HSACT_BIT] = hs_act;
    w[CFG_DIV_MSB:CFG_DIV_LSB] = div;
    w[CFG_TURBO_BIT] = turbo;
    return w;
  endfunction

endpackage

// File: rtl/hsclk_sel_ctrl_sync_bit.sv
// Multi-flop synchroniser for a single level signal.
//  lsclk_in : destination clock
//  rst_b    : asynchronous active-low reset, clears every stage to 0
//  d_i      : asynchronous input level
//  q_o      : input level after STAGES destination-clock flops
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic lsclk_in,
  input  logic rst_b,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge lsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/hsclk_sel_ctrl.sv
// Fast-clock select controller, clocked by host PHI2 (lsclk_in).
// Decides when the CPU may run from the fast clock: drops to the slow clock
// for host bus accesses and re-requests turbo after a clean holdoff period.
// Also holds the CPU speed config register and a sticky switch-timeout flag.
//  lsclk_in        : host PHI2 clock
//  rst_b           : asynchronous active-low reset
//  slow_req        : current access needs the host bus
//  cfg_wr/cfg_wdata: config write ([0] turbo_en, [2:1] div_sel, [7] W1C err)
//  lsclk_selected  : clock switch reports slow clock selected (lsclk domain)
//  hsclk_selected  : clock switch reports fast clock selected (hs domain)
//  hsclk_sel       : request fast clock
//  cpuclk_div_sel  : fast clock divider select
//  cfg_rdata       : config/status read-back
//  hs_active       : controller is in HS_RUN
module hsclk_sel_ctrl
  import hsclk_sel_ctrl_pkg::*;
#(
  parameter int unsigned HOLDOFF_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter logic        TURBO_RESET    = 1'b0
) (
  input  logic       lsclk_in,
  input  logic       rst_b,
  input  logic       slow_req,
  input  logic       cfg_wr,
  input  logic [7:0] cfg_wdata,
  input  logic       lsclk_selected,
  input  logic       hsclk_selected,
  output logic       hsclk_sel,
  output logic [1:0] cpuclk_div_sel,
  output logic [7:0] cfg_rdata,
  output logic       hs_active
);

  localparam int unsigned HW = $clog2(HOLDOFF_CYCLES + 1);
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [HW-1:0] HOLDOFF_RELOAD = HW'(HOLDOFF_CYCLES);
  localparam logic [HW-1:0] HOLDOFF_ONE    = HW'(1);
  localparam logic [TW-1:0] TMO_LAST       = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_ONE        = TW'(1);

  state_e        state_q, state_d;
  logic [HW-1:0] holdoff_q, holdoff_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          turbo_q, turbo_d;
  logic [1:0]    div_pend_q, div_pend_d;
  logic [1:0]    div_sel_q, div_sel_d;
  logic          err_q, err_d;
  logic          hs_sel_q, hs_sel_d;
  logic          hs_s;
  logic          drop;
  logic          err_set;
  logic          unused_wdata;

  assign unused_wdata = ^cfg_wdata[6:3];

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_hs_sync (
    .lsclk_in (lsclk_in),
    .rst_b    (rst_b),
    .d_i      (hsclk_selected),
    .q_o      (hs_s)
  );

  // Decisions use the registered turbo_en, so a config write takes effect
  // one cycle after it is sampled.
  assign drop = slow_req | ~turbo_q;

  always_comb begin
    state_d    = state_q;
    holdoff_d  = holdoff_q;
    tmo_d      = tmo_q;
    turbo_d    = turbo_q;
    div_pend_d = div_pend_q;
    div_sel_d  = div_sel_q;
    err_d      = err_q;
    err_set    = 1'b0;

    unique case (state_q)
      LS_RUN: begin
        // Only state where the divider may change: fast clock is off
        div_sel_d = div_pend_q;
        if (slow_req) begin
          holdoff_d = HOLDOFF_RELOAD;
        end else if (holdoff_q != '0) begin
          holdoff_d = holdoff_q - HOLDOFF_ONE;
        end
        if (turbo_q && !slow_req && (holdoff_q == '0)) begin
          state_d = HS_REQ;
        end
      end
      HS_REQ: begin
        if (drop) begin
          state_d = LS_REQ;
        end else if (hs_s) begin
          state_d = HS_RUN;
        end else if (tmo_q == TMO_LAST) begin
          err_set = 1'b1;
          state_d = LS_REQ;
        end
      end
      HS_RUN: begin
        if (drop) begin
          state_d = LS_REQ;
        end
      end
      LS_REQ: begin
        // A stuck switch keeps err asserted here; hsclk_sel stays low
        if (lsclk_selected && !hs_s) begin
          state_d   = LS_RUN;
          holdoff_d = HOLDOFF_RELOAD;
        end else if (tmo_q == TMO_LAST) begin
          err_set = 1'b1;
        end
      end
      default: begin
        state_d = LS_RUN;
      end
    endcase

    // Timeout counter restarts on any state change and saturates at its
    // last value, so a switch that never completes keeps raising err.
    if (state_d != state_q) begin
      tmo_d = '0;
    end else if (((state_q == HS_REQ) || (state_q == LS_REQ)) && (tmo_q != TMO_LAST)) begin
      tmo_d = tmo_q + TMO_ONE;
    end

    if (cfg_wr) begin
      turbo_d    = cfg_wdata[CFG_TURBO_BIT];
      div_pend_d = cfg_wdata[CFG_DIV_MSB:CFG_DIV_LSB];
      if (cfg_wdata[CFG_ERR_BIT]) begin
        err_d = 1'b0;
      end
    end
    // A timeout in the same cycle as a clear must not be lost
    if (err_set) begin
      err_d = 1'b1;
    end

    hs_sel_d = (state_d == HS_REQ) || (state_d == HS_RUN);
  end

  always_ff @(posedge lsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= LS_RUN;
      holdoff_q  <= HOLDOFF_RELOAD;
      tmo_q      <= '0;
      turbo_q    <= TURBO_RESET;
      div_pend_q <= 2'b00;
      div_sel_q  <= 2'b00;
      err_q      <= 1'b0;
      hs_sel_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      holdoff_q  <= holdoff_d;
      tmo_q      <= tmo_d;
      turbo_q    <= turbo_d;
      div_pend_q <= div_pend_d;
      div_sel_q  <= div_sel_d;
      err_q      <= err_d;
      hs_sel_q   <= hs_sel_d;
    end
  end

  assign hsclk_sel      = hs_sel_q;
  assign cpuclk_div_sel = div_sel_q;
  assign hs_active      = (state_q == HS_RUN);
  assign cfg_rdata      = pack_rdata(err_q, hs_active, div_pend_q, turbo_q);

endmodule

// File: tb/tb_hsclk_sel_ctrl.sv
// Directed self-checking bench for hsclk_sel_ctrl (default parameters:
// holdoff 4, timeout 64, 2 sync stages, turbo off at reset).
// The clock switch is modelled by driving hsclk_selected/lsclk_selected
// directly; expected values are hand-computed edge by edge.
module tb_hsclk_sel_ctrl;

  logic       lsclk_in;
  logic       rst_b;
  logic       slow_req;
  logic       cfg_wr;
  logic [7:0] cfg_wdata;
  logic       lsclk_selected;
  logic       hsclk_selected;
  logic       hsclk_sel;
  logic [1:0] cpuclk_div_sel;
  logic [7:0] cfg_rdata;
  logic       hs_active;

  int total;
  int bad;

  hsclk_sel_ctrl dut (
    .lsclk_in       (lsclk_in),
    .rst_b          (rst_b),
    .slow_req       (slow_req),
    .cfg_wr         (cfg_wr),
    .cfg_wdata      (cfg_wdata),
    .lsclk_selected (lsclk_selected),
    .hsclk_selected (hsclk_selected),
    .hsclk_sel      (hsclk_sel),
    .cpuclk_div_sel (cpuclk_div_sel),
    .cfg_rdata      (cfg_rdata),
    .hs_active      (hs_active)
  );

  initial begin
    lsclk_in = 1'b0;
    forever #5 lsclk_in = ~lsclk_in;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, advance past the next posedge, then return
  // the pulse-type inputs to idle.
  task automatic applyStimulus(input logic sr, input logic wr, input logic [7:0] wd);
    slow_req  = sr;
    cfg_wr    = wr;
    cfg_wdata = wd;
    @(posedge lsclk_in);
    #1;
    slow_req  = 1'b0;
    cfg_wr    = 1'b0;
    cfg_wdata = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00);
  endtask

  task automatic setAck(input logic hs);
    hsclk_selected = hs;
    lsclk_selected = ~hs;
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    rst_b          = 1'b1;
    slow_req       = 1'b0;
    cfg_wr         = 1'b0;
    cfg_wdata      = 8'h00;
    setAck(1'b0);
    #2 rst_b = 1'b0;
    #10;

    // Reset state
    checkOutput("rst_sel", {7'd0, hsclk_sel}, 8'h00);
    checkOutput("rst_rdata", cfg_rdata, 8'h00);
    checkOutput("rst_div", {6'd0, cpuclk_div_sel}, 8'h00);
    checkOutput("rst_hsact", {7'd0, hs_active}, 8'h00);
    rst_b = 1'b1;

    // 1: turbo on right after reset; holdoff runs 4->0, request on 5th edge
    applyStimulus(1'b0, 1'b1, 8'h01);
    checkOutput("t1_rdata_turbo", cfg_rdata, 8'h01);
    idle(3);
    checkOutput("t1_sel_early", {7'd0, hsclk_sel}, 8'h00);
    idle(1);
    checkOutput("t1_sel_rise", {7'd0, hsclk_sel}, 8'h01);
    setAck(1'b1);
    idle(2);
    checkOutput("t1_hsact_sync", {7'd0, hs_active}, 8'h00);
    idle(1);
    checkOutput("t1_hsact", {7'd0, hs_active}, 8'h01);
    checkOutput("t1_rdata_hs", cfg_rdata, 8'h11);

    // 2: one-cycle slow_req drops the request on that edge
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("t2_sel_drop", {7'd0, hsclk_sel}, 8'h00);
    checkOutput("t2_hsact_drop", {7'd0, hs_active}, 8'h00);
    idle(2);
    checkOutput("t2_sel_lsreq", {7'd0, hsclk_sel}, 8'h00);
    setAck(1'b0);
    idle(3);
    idle(2);
    applyStimulus(1'b1, 1'b0, 8'h00);
    idle(4);
    checkOutput("t2_holdoff_restart", {7'd0, hsclk_sel}, 8'h00);
    idle(1);
    checkOutput("t2_rerequest", {7'd0, hsclk_sel}, 8'h01);

    // 3: divider written in HS_RUN is held until LS_RUN
    setAck(1'b1);
    idle(3);
    checkOutput("t3_hsact", {7'd0, hs_active}, 8'h01);
    applyStimulus(1'b0, 1'b1, 8'h05);
    checkOutput("t3_div_hold_hs", {6'd0, cpuclk_div_sel}, 8'h00);
    checkOutput("t3_rdata_pend", cfg_rdata, 8'h15);
    idle(2);
    checkOutput("t3_div_hold_hs2", {6'd0, cpuclk_div_sel}, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h00);
    setAck(1'b0);
    idle(3);
    checkOutput("t3_div_hold_exit", {6'd0, cpuclk_div_sel}, 8'h00);
    idle(1);
    checkOutput("t3_div_apply", {6'd0, cpuclk_div_sel}, 8'h02);
    idle(4);
    checkOutput("t3_rerequest", {7'd0, hsclk_sel}, 8'h01);

    // 5: turbo off during HS_REQ aborts one edge after the write
    applyStimulus(1'b0, 1'b1, 8'h04);
    checkOutput("t5_sel_write_edge", {7'd0, hsclk_sel}, 8'h01);
    setAck(1'b1);
    idle(1);
    checkOutput("t5_abort", {7'd0, hsclk_sel}, 8'h00);
    idle(2);
    checkOutput("t5_no_hsrun", {7'd0, hs_active}, 8'h00);
    checkOutput("t5_rdata", cfg_rdata, 8'h04);
    setAck(1'b0);
    idle(3);

    // 4: switch never acknowledges -> timeout after 64 HS_REQ cycles
    applyStimulus(1'b0, 1'b1, 8'h05);
    idle(4);
    checkOutput("t4_req", {7'd0, hsclk_sel}, 8'h01);
    idle(63);
    checkOutput("t4_sel_before_tmo", {7'd0, hsclk_sel}, 8'h01);
    idle(1);
    checkOutput("t4_sel_tmo", {7'd0, hsclk_sel}, 8'h00);
    checkOutput("t4_err_set", cfg_rdata, 8'h85);
    applyStimulus(1'b0, 1'b1, 8'h85);
    checkOutput("t4_err_clear", cfg_rdata, 8'h05);
    idle(5);
    checkOutput("t4_req2", {7'd0, hsclk_sel}, 8'h01);
    idle(63);
    applyStimulus(1'b0, 1'b1, 8'h85);
    checkOutput("t4_set_wins", cfg_rdata, 8'h85);
    checkOutput("t4_sel_tmo2", {7'd0, hsclk_sel}, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h80);
    checkOutput("t4_clear_80", cfg_rdata, 8'h00);

    // 6: div 11 passes through; reset mid HS_RUN clears everything at once
    applyStimulus(1'b0, 1'b1, 8'h07);
    idle(1);
    checkOutput("t6_div11", {6'd0, cpuclk_div_sel}, 8'h03);
    idle(3);
    checkOutput("t6_req", {7'd0, hsclk_sel}, 8'h01);
    setAck(1'b1);
    idle(3);
    checkOutput("t6_hsact", {7'd0, hs_active}, 8'h01);
    #3;
    rst_b = 1'b0;
    #1;
    checkOutput("t6_rst_sel", {7'd0, hsclk_sel}, 8'h00);
    checkOutput("t6_rst_rdata", cfg_rdata, 8'h00);
    checkOutput("t6_rst_div", {6'd0, cpuclk_div_sel}, 8'h00);
    checkOutput("t6_rst_hsact", {7'd0, hs_active}, 8'h00);
    setAck(1'b0);
    #10;
    rst_b = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
